// File: rtl/fifo_ptr_flag_unit_pkg.sv
// Shared constants and pointer-code helpers for the async FIFO pointer/flag units.
// Helpers operate on FN_W-bit vectors; narrower callers zero-extend and truncate.
package fifo_flag_pkg;

  localparam int MODE_WR = 0;
  localparam int MODE_RD = 1;
  localparam int FN_W    = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = g;
    for (int i = 1; i < FN_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_flag_unit_gray2bin.sv
// Gray to binary converter for the synchronised remote pointer; purely combinational.
// No flow control: output follows input within the same cycle.
module fifo_gray2bin #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits from the MSB down to itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_ptr_flag_unit.sv
// One side of an async FIFO: local pointer, registered Full/Empty, Almost, level, sticky error.
// Flags/level update one edge after a local accept or remote pointer change; requests while flag=1 are dropped.
module fifo_ptr_flag_unit
  import fifo_flag_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MODE       = MODE_WR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_req,
  input  logic [ADDR_WIDTH:0]   sync_RemoteGray,
  input  logic [ADDR_WIDTH:0]   almost_thresh,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] LocalAddr,
  output logic [ADDR_WIDTH:0]   LocalGray,
  output logic                  flag,
  output logic                  almost_flag,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  accept,
  output logic                  err_sticky
);

  localparam int            PW       = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH    = PW'(2 ** ADDR_WIDTH);
  localparam logic          RST_FLAG = (MODE == MODE_RD);

  logic [PW-1:0] bin_q;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl_next;
  logic          flag_next;
  logic          almost_next;

  fifo_gray2bin #(.WIDTH(PW)) u_remote_g2b (
    .gray (sync_RemoteGray),
    .bin  (rbin)
  );

  assign accept    = inc_req & ~flag;
  assign bin_next  = bin_q + {{ADDR_WIDTH{1'b0}}, accept};
  assign gray_next = PW'(bin2gray(FN_W'(bin_next)));
  assign LocalAddr = bin_q[ADDR_WIDTH-1:0];

  // Modulo subtraction keeps the level correct across pointer wrap.
  if (MODE == MODE_WR) begin : g_wr
    assign lvl_next    = bin_next - rbin;
    assign flag_next   = (lvl_next == DEPTH);
    assign almost_next = (lvl_next >= almost_thresh);
  end else begin : g_rd
    assign lvl_next    = rbin - bin_next;
    assign flag_next   = (lvl_next == '0);
    assign almost_next = (lvl_next <= almost_thresh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q       <= '0;
      LocalGray   <= '0;
      level       <= '0;
      flag        <= RST_FLAG;
      almost_flag <= RST_FLAG;
      err_sticky  <= 1'b0;
    end else begin
      bin_q       <= bin_next;
      LocalGray   <= gray_next;
      level       <= lvl_next;
      flag        <= flag_next;
      almost_flag <= almost_next;
      // A dropped request wins over a clear in the same cycle.
      err_sticky  <= (err_sticky & ~err_clr) | (inc_req & flag);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_flag_unit.sv
// Bench for fifo_ptr_flag_unit: write-side and read-side instances (DEPTH=4) against
// an occupancy-count model, directed boundary sequences then randomized traffic.
module tb_fifo_ptr_flag_unit;

  localparam int AW = 2;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          w_inc = 1'b0, w_clr = 1'b0, r_inc = 1'b0, r_clr = 1'b0;
  logic [AW:0]   w_rg = '0, r_rg = '0, w_th = 3'd3, r_th = 3'd3;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   w_gray, r_gray, w_lvl, r_lvl;
  logic          w_flag, r_flag, w_alm, r_alm, w_acc, r_acc, w_err, r_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: unbounded counts of accepted words on each side; level is their plain difference.
  int mw_l, mw_r, mw_lvl, mr_l, mr_r, mr_lvl;
  bit mw_flag, mw_alm, mw_err, mr_flag, mr_alm, mr_err;

  logic [2:0] gtab [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

  fifo_ptr_flag_unit #(.ADDR_WIDTH(AW), .MODE(0)) u_wr (
    .clk(clk), .rst(rst), .inc_req(w_inc), .sync_RemoteGray(w_rg), .almost_thresh(w_th),
    .err_clr(w_clr), .LocalAddr(w_addr), .LocalGray(w_gray), .flag(w_flag),
    .almost_flag(w_alm), .level(w_lvl), .accept(w_acc), .err_sticky(w_err)
  );

  fifo_ptr_flag_unit #(.ADDR_WIDTH(AW), .MODE(1)) u_rd (
    .clk(clk), .rst(rst), .inc_req(r_inc), .sync_RemoteGray(r_rg), .almost_thresh(r_th),
    .err_clr(r_clr), .LocalAddr(r_addr), .LocalGray(r_gray), .flag(r_flag),
    .almost_flag(r_alm), .level(r_lvl), .accept(r_acc), .err_sticky(r_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int gray_of(input int n);
    int b;
    b = n % 8;
    return b ^ (b >> 1);
  endfunction

  task automatic reset_models();
    mw_l = 0; mw_r = 0; mw_lvl = 0; mw_flag = 0; mw_alm = 0; mw_err = 0;
    mr_l = 0; mr_r = 0; mr_lvl = 0; mr_flag = 1; mr_alm = 1; mr_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_w_flag", w_flag, 0);
    check("rst_w_alm",  w_alm,  0);
    check("rst_w_lvl",  w_lvl,  0);
    check("rst_w_gray", w_gray, 0);
    check("rst_w_err",  w_err,  0);
    check("rst_r_flag", r_flag, 1);
    check("rst_r_alm",  r_alm,  1);
    check("rst_r_lvl",  r_lvl,  0);
    check("rst_r_addr", r_addr, 0);
    reset_models();
    w_inc = 0; r_inc = 0; w_clr = 0; r_clr = 0; w_rg = '0; r_rg = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive both sides, check accept, advance the model, check registered outputs.
  task automatic cycle(input bit winc, input bit wclr, input int wrem,
                       input bit rinc, input bit rclr, input int rrem);
    bit wa, ra;
    w_inc = winc; w_clr = wclr; w_rg = 3'(gray_of(wrem));
    r_inc = rinc; r_clr = rclr; r_rg = 3'(gray_of(rrem));
    #1;
    wa = winc && !mw_flag;
    ra = rinc && !mr_flag;
    check("w_accept", w_acc, int'(wa));
    check("r_accept", r_acc, int'(ra));
    @(posedge clk);
    #1;
    mw_err = (mw_err && !wclr) || (winc && mw_flag);
    mw_l   = mw_l + int'(wa);
    mw_r   = wrem;
    mw_lvl = mw_l - mw_r;
    mw_flag = (mw_lvl == D);
    mw_alm  = (mw_lvl >= int'(w_th));
    mr_err = (mr_err && !rclr) || (rinc && mr_flag);
    mr_l   = mr_l + int'(ra);
    mr_r   = rrem;
    mr_lvl = mr_r - mr_l;
    mr_flag = (mr_lvl == 0);
    mr_alm  = (mr_lvl <= int'(r_th));
    check("w_level", w_lvl, mw_lvl);
    check("w_full",  w_flag, int'(mw_flag));
    check("w_afull", w_alm, int'(mw_alm));
    check("w_gray",  w_gray, gray_of(mw_l));
    check("w_addr",  w_addr, mw_l % D);
    check("w_err",   w_err, int'(mw_err));
    check("r_level", r_lvl, mr_lvl);
    check("r_empty", r_flag, int'(mr_flag));
    check("r_aempty", r_alm, int'(mr_alm));
    check("r_gray",  r_gray, gray_of(mr_l));
    check("r_addr",  r_addr, mr_l % D);
    check("r_err",   r_err, int'(mr_err));
  endtask

  task automatic wdo(input bit inc, input bit clr, input int rem);
    cycle(inc, clr, rem, 1'b0, 1'b0, mr_r);
  endtask

  task automatic rdo(input bit inc, input bit clr, input int rem);
    cycle(1'b0, 1'b0, mw_r, inc, clr, rem);
  endtask

  initial begin
    int wrem, rrem;
    reset_models();
    do_reset();

    // Fill to Full, then overflow attempt
    w_th = 3'd3;
    for (int i = 0; i < 4; i++) begin
      wdo(1, 0, 0);
      check("fill_lvl", w_lvl, i + 1);
      check("fill_alm", w_alm, (i >= 2) ? 1 : 0);
    end
    check("fill_full", w_flag, 1);
    wdo(1, 0, 0);
    check("ovf_err", w_err, 1);
    check("ovf_addr_held", w_addr, 0);
    check("ovf_lvl", w_lvl, 4);

    // Remote advance coinciding with a dropped request
    wdo(0, 1, 0);
    check("clr_err", w_err, 0);
    wdo(1, 0, 1);
    check("sim_lvl", w_lvl, 3);
    check("sim_flag", w_flag, 0);
    check("sim_err", w_err, 1);
    wdo(1, 0, 1);
    check("refill_full", w_flag, 1);
    wdo(1, 1, 1);
    check("set_beats_clr", w_err, 1);

    // Read side drain
    do_reset();
    r_th = 3'd3;
    rdo(0, 0, 3);
    check("drain_start_lvl", r_lvl, 3);
    check("drain_start_empty", r_flag, 0);
    for (int i = 0; i < 3; i++) begin
      rdo(1, 0, 3);
      check("drain_lvl", r_lvl, 2 - i);
    end
    check("drain_empty", r_flag, 1);
    rdo(1, 0, 3);
    check("udf_err", r_err, 1);
    rdo(0, 1, 3);
    check("udf_clr", r_err, 0);

    // Wrap with the remote one cycle behind
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wdo(1, 0, mw_l);
      check("wrap_gray", w_gray, int'(gtab[i % 8]));
      check("wrap_lvl_le1", (w_lvl <= 3'd1), 1);
      check("wrap_noflag", w_flag, 0);
    end

    // Threshold extremes on the write side
    do_reset();
    w_th = 3'd0;
    wdo(0, 0, 0);
    check("thr0_alm", w_alm, 1);
    w_th = 3'd5;
    for (int i = 0; i < 4; i++) wdo(1, 0, 0);
    check("thr5_full", w_flag, 1);
    check("thr5_alm", w_alm, 0);

    // Randomized traffic with stale-but-monotonic remote pointers
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      w_th = 3'($urandom_range(0, 7));
      r_th = 3'($urandom_range(0, 7));
      if (blk == 4) do_reset();
      for (int k = 0; k < 60; k++) begin
        wrem = mw_r + ((($urandom % 2) == 1 && mw_r < mw_l) ? 1 : 0);
        rrem = mr_r + ((($urandom % 2) == 1 && (mr_r - mr_l) < D) ? 1 : 0);
        cycle(($urandom % 3) != 0, ($urandom % 16) == 0, wrem,
              ($urandom % 2) == 1, ($urandom % 16) == 0, rrem);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
